// File: rtl/tfab_pkg.sv
// Shared trit-fabric definitions: trit lane codes, packed-word constants and responder FSM states.
package tfab_pkg;
  localparam int TRIT_WORD_W = 24;
  localparam int POW3_15     = 14348907;

  localparam logic [1:0] TRIT_ZERO = 2'b00;
  localparam logic [1:0] TRIT_POS  = 2'b01;
  localparam logic [1:0] TRIT_NEG  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_UNPACK,
    ST_RESP
  } fsm_state_t;

  // Base-3 digit (0..2) to signed trit lane code.
  function automatic logic [1:0] trit_code(input logic [1:0] digit);
    case (digit)
      2'd1:    trit_code = TRIT_POS;
      2'd2:    trit_code = TRIT_NEG;
      default: trit_code = TRIT_ZERO;
    endcase
  endfunction
endpackage

// File: rtl/trit_unpacker.sv
// Iterative base-3 decoder: one digit per cycle, digit 0 produced on the start edge.
// Used by frame_mem_responder only when TRIT_UNPACK_EN is defined.
module trit_unpacker
  import tfab_pkg::*;
#(
  parameter int LANE_COUNT = 15
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [TRIT_WORD_W-1:0]       word,
  output logic                         busy,
  output logic                         done,
  output logic                         invalid,
  output logic [LANE_COUNT-1:0][1:0]   lane_vec
);
  localparam int IDX_W = $clog2(LANE_COUNT);

  logic [TRIT_WORD_W-1:0] rem_q;
  logic [IDX_W-1:0]       idx_q;
  logic [TRIT_WORD_W-1:0] src;
  logic [TRIT_WORD_W-1:0] quot;
  logic [1:0]             digit;

  // The start cycle decodes straight from the incoming word so the full
  // decode finishes one cycle earlier and done lands on the 15th cycle.
  assign src   = start ? word : rem_q;
  assign digit = 2'(src % TRIT_WORD_W'(3));
  assign quot  = src / TRIT_WORD_W'(3);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_q    <= '0;
      idx_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      invalid  <= 1'b0;
      lane_vec <= '0;
    end else if (start) begin
      rem_q       <= quot;
      idx_q       <= IDX_W'(1);
      busy        <= 1'b1;
      done        <= 1'b0;
      invalid     <= word >= TRIT_WORD_W'(POW3_15);
      lane_vec    <= '0;
      lane_vec[0] <= trit_code(digit);
    end else if (busy) begin
      lane_vec[idx_q] <= trit_code(digit);
      rem_q           <= quot;
      idx_q           <= idx_q + 1'b1;
      if (idx_q == IDX_W'(LANE_COUNT-1)) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end
endmodule

// File: rtl/frame_mem_responder.sv
// Memory-side responder: one SRAM word per beat returned on lane_data with a mem_ready pulse.
// TRIT_UNPACK_EN selects base-3 trit unpacking of each word (adds a 15-cycle UNPACK state).
module frame_mem_responder
  import tfab_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int LANE_COUNT   = 15,
  parameter int SRAM_AW      = 12,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    engine_enable,
  input  logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_ready,
  output logic [2*LANE_COUNT-1:0] lane_data,
  output logic                    sram_rd_en,
  output logic [SRAM_AW-1:0]      sram_addr,
  input  logic [TRIT_WORD_W-1:0]  sram_rdata,
  output logic                    addr_err,
  output logic [15:0]             beat_count
);
  localparam int LANE_W = 2*LANE_COUNT;

  fsm_state_t      state_q, state_d;
  logic [2:0]      wcnt_q;
  logic            oor_q;
  logic            abort_q;
  logic            in_range;
  logic            last_wait;
  logic            abort;
  logic            unpack_done;
  logic            beat_bad;
  logic [LANE_W-1:0] beat_data;
  fsm_state_t      after_wait;

  assign in_range  = (mem_addr[ADDR_WIDTH-1:SRAM_AW] == '0);
  assign last_wait = (state_q == ST_WAIT) && (wcnt_q == 3'(READ_LATENCY-1));
  // Enable may drop at any point of the beat; remember it so the beat is dropped.
  assign abort     = abort_q | ~engine_enable;

`ifdef TRIT_UNPACK_EN
  logic                      up_busy;
  logic                      up_done;
  logic                      up_invalid;
  logic [LANE_COUNT-1:0][1:0] up_lanes;

  trit_unpacker #(.LANE_COUNT(LANE_COUNT)) u_unpack (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (last_wait),
    .word     (sram_rdata),
    .busy     (up_busy),
    .done     (up_done),
    .invalid  (up_invalid),
    .lane_vec (up_lanes)
  );

  assign after_wait  = ST_UNPACK;
  assign unpack_done = up_done & ~up_busy;
  assign beat_bad    = up_invalid & ~oor_q;
  assign beat_data   = (oor_q | up_invalid) ? '0 : LANE_W'(up_lanes);
`else
  assign after_wait  = ST_RESP;
  assign unpack_done = 1'b0;
  assign beat_bad    = 1'b0;
  assign beat_data   = oor_q ? '0 : {{(LANE_W-TRIT_WORD_W){1'b0}}, sram_rdata};
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (engine_enable) state_d = ST_ISSUE;
      ST_ISSUE:  state_d = ST_WAIT;
      ST_WAIT:   if (last_wait) state_d = abort ? ST_IDLE : after_wait;
      ST_UNPACK: begin
        if (abort)            state_d = ST_IDLE;
        else if (unpack_done) state_d = ST_RESP;
      end
      ST_RESP:   state_d = engine_enable ? ST_ISSUE : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign mem_ready  = (state_q == ST_RESP);
  assign sram_rd_en = (state_q == ST_ISSUE) && in_range;
  assign sram_addr  = (state_q == ST_ISSUE) ? mem_addr[SRAM_AW-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      wcnt_q     <= '0;
      oor_q      <= 1'b0;
      abort_q    <= 1'b0;
      lane_data  <= '0;
      addr_err   <= 1'b0;
      beat_count <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && engine_enable) begin
        addr_err   <= 1'b0;
        beat_count <= '0;
      end
      if (state_q == ST_ISSUE) begin
        oor_q   <= ~in_range;
        abort_q <= ~engine_enable;
        wcnt_q  <= '0;
        if (!in_range) addr_err <= 1'b1;
      end
      if (state_q == ST_WAIT) begin
        wcnt_q <= wcnt_q + 1'b1;
        if (!engine_enable) abort_q <= 1'b1;
      end
      // lane_data only moves on entry to RESP so it is stable across the pulse.
      if (state_d == ST_RESP) begin
        lane_data  <= beat_data;
        beat_count <= beat_count + 16'd1;
        if (beat_bad) addr_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_frame_mem_responder.sv
// Randomized bench for frame_mem_responder against a behavioural SRAM/beat model.
module tb_frame_mem_responder;
  localparam int RL = 2;
`ifdef TRIT_UNPACK_EN
  localparam int LAT = RL + 2 + 15;
`else
  localparam int LAT = RL + 2;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        engine_enable = 1'b0;
  logic [31:0] mem_addr = '0;
  logic        mem_ready;
  logic [29:0] lane_data;
  logic        sram_rd_en;
  logic [11:0] sram_addr;
  logic [23:0] sram_rdata;
  logic        addr_err;
  logic [15:0] beat_count;

  logic [23:0] sram    [4096];
  logic [23:0] rd_pipe [RL];
  int total = 0;
  int bad   = 0;
  logic [31:0] q[$];

  frame_mem_responder #(.READ_LATENCY(RL)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .engine_enable (engine_enable),
    .mem_addr      (mem_addr),
    .mem_ready     (mem_ready),
    .lane_data     (lane_data),
    .sram_rd_en    (sram_rd_en),
    .sram_addr     (sram_addr),
    .sram_rdata    (sram_rdata),
    .addr_err      (addr_err),
    .beat_count    (beat_count)
  );

  always #5 clk = ~clk;

  // SRAM with RL-cycle read latency; unstrobed cycles return junk.
  always @(posedge clk) begin
    rd_pipe[0] <= sram_rd_en ? sram[sram_addr] : 24'($urandom);
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign sram_rdata = rd_pipe[RL-1];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [29:0] exp_lanes(input logic [31:0] a, output bit err);
    logic [23:0] w;
    int          v;
    logic [29:0] r;
    r   = '0;
    err = 1'b0;
    if (a[31:12] != 20'd0) begin
      err = 1'b1;
      return '0;
    end
    w = sram[a[11:0]];
`ifdef TRIT_UNPACK_EN
    if (int'(w) >= 14348907) begin
      err = 1'b1;
      return '0;
    end
    v = int'(w);
    for (int i = 0; i < 15; i++) begin
      case (v % 3)
        0:       r[2*i +: 2] = 2'b00;
        1:       r[2*i +: 2] = 2'b01;
        default: r[2*i +: 2] = 2'b11;
      endcase
      v = v / 3;
    end
`else
    v    = 0;
    r    = {6'b0, w};
`endif
    return r;
  endfunction

  // Acts as the frame controller: serves the address list, optionally dropping
  // enable in the WAIT phase of beat abort_at.
  task automatic run_beats(input logic [31:0] a[$], input int abort_at);
    bit          err_acc;
    bit          e;
    bit          oor;
    logic [29:0] exp;
    int          waited;
    int          strobes;
    err_acc = 1'b0;
    @(negedge clk);
    mem_addr      = a[0];
    engine_enable = 1'b1;
    for (int i = 0; i < a.size(); i++) begin
      waited  = 0;
      strobes = 0;
      exp     = exp_lanes(a[i], e);
      oor     = (a[i][31:12] != 20'd0);
      do begin
        @(negedge clk);
        waited++;
        if (sram_rd_en) begin
          strobes++;
          chk("rd_addr", sram_addr, a[i][11:0]);
        end
        if (i == abort_at && waited == 2) engine_enable = 1'b0;
      end while (!mem_ready && waited < LAT + 30);
      if (i == abort_at) begin
        chk("abort_noready", mem_ready, 1'b0);
        chk("abort_cnt", beat_count, i);
        chk("abort_strobes", strobes, oor ? 0 : 1);
        return;
      end
      chk("latency", waited, LAT);
      chk("strobes", strobes, oor ? 0 : 1);
      err_acc |= e;
      chk("lane_data", lane_data, exp);
      chk("beat_count", beat_count, i + 1);
      chk("addr_err", addr_err, err_acc);
      if (i + 1 < a.size()) mem_addr = a[i+1];
      else                  engine_enable = 1'b0;
    end
    repeat (3) begin
      @(negedge clk);
      chk("idle_ready", mem_ready | sram_rd_en, 1'b0);
    end
    chk("lane_hold", lane_data, exp);
  endtask

  task automatic reset_mid_wait();
    @(negedge clk);
    mem_addr      = 32'h20;
    engine_enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst_ready", mem_ready, 1'b0);
    chk("rst_lane", lane_data, 30'd0);
    chk("rst_rden", sram_rd_en, 1'b0);
    chk("rst_err", addr_err, 1'b0);
    chk("rst_cnt", beat_count, 16'd0);
    repeat (2) @(negedge clk);
    engine_enable = 1'b0;
    reset_n       = 1'b1;
    repeat (RL + 6) begin
      @(negedge clk);
      chk("rst_noready", mem_ready, 1'b0);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) sram[i] = 24'($urandom);
    sram[5] = 24'h00ABCD;
    sram[6] = 24'd5;
    sram[7] = 24'hFFFFFF;
    sram[8] = 24'd14348906;
    sram[9] = 24'd14348907;

    repeat (2) @(negedge clk);
    chk("reset_ready", mem_ready, 1'b0);
    chk("reset_lane", lane_data, 30'd0);
    chk("reset_rden", sram_rd_en, 1'b0);
    chk("reset_saddr", sram_addr, 12'd0);
    chk("reset_err", addr_err, 1'b0);
    chk("reset_cnt", beat_count, 16'd0);
    reset_n = 1'b1;

    q.delete(); q.push_back(32'h5);
    run_beats(q, -1);

    q.delete();
    q.push_back(32'h6); q.push_back(32'h7); q.push_back(32'h8);
    q.push_back(32'h9); q.push_back(32'hFFF);
    run_beats(q, -1);

    q.delete();
    q.push_back(32'h0001_0000); q.push_back(32'h1000); q.push_back(32'h3);
    run_beats(q, -1);

    q.delete();
    for (int i = 0; i < 4; i++) q.push_back(32'h10 + 32'(i));
    run_beats(q, -1);

    for (int r = 0; r < 6; r++) begin
      q.delete();
      for (int i = 0; i < int'($urandom_range(3, 8)); i++) begin
        if ($urandom_range(0, 5) == 0) q.push_back($urandom | 32'h0000_1000);
        else                           q.push_back(32'($urandom_range(0, 4095)));
      end
      run_beats(q, -1);
    end

    q.delete();
    for (int i = 0; i < 4; i++) q.push_back(32'($urandom_range(0, 4095)));
    run_beats(q, 2);

    q.delete(); q.push_back(32'h11); q.push_back(32'h12);
    run_beats(q, -1);

    reset_mid_wait();

    q.delete(); q.push_back(32'h5);
    run_beats(q, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
